// File: rtl/rh_axi4_pkg.sv
// Shared types and address arithmetic for the AXI4 write-address burst generator.
package rh_axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic {
    GEN_IDLE  = 1'b0,
    GEN_BURST = 1'b1
  } gen_state_e;

  localparam int ADDR_MAX_W     = 64;
  localparam int BOUNDARY_4K    = 4096;
  localparam int BOUNDARY_SHIFT = $clog2(BOUNDARY_4K);

  // Address of the beat following addr; callers zero-extend to 64 bits and truncate the result.
  function automatic logic [ADDR_MAX_W-1:0] next_beat_addr(
    input logic [ADDR_MAX_W-1:0] addr,
    input logic [2:0]            size,
    input burst_e                burst,
    input logic [ADDR_MAX_W-1:0] wrap_low,
    input logic [ADDR_MAX_W-1:0] span
  );
    logic [ADDR_MAX_W-1:0] bytes;
    logic [ADDR_MAX_W-1:0] nxt;
    bytes = 64'd1 << size;
    nxt   = (addr & ~(bytes - 64'd1)) + bytes;
    case (burst)
      BURST_FIXED: next_beat_addr = addr;
      BURST_WRAP:  next_beat_addr = (nxt == wrap_low + span) ? wrap_low : nxt;
      default:     next_beat_addr = nxt;
    endcase
  endfunction

endpackage

// File: rtl/rh_axi4_aw_fifo.sv
// Synchronous FIFO holding accepted AW requests; payload type set by the parent.
module rh_axi4_aw_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/rh_axi4_aw_burst_gen.sv
// AXI4 AW-channel slave: buffers requests and expands each into per-beat addresses.
module rh_axi4_aw_burst_gen
  import rh_axi4_pkg::*;
#(
  parameter int IW    = 4,
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          AWVALID,
  output logic          AWREADY,
  input  logic [IW-1:0] AWID,
  input  logic [AW-1:0] AWADDR,
  input  logic [7:0]    AWLEN,
  input  logic [2:0]    AWSIZE,
  input  logic [1:0]    AWBURST,
  output logic          beat_valid,
  input  logic          beat_ready,
  output logic [AW-1:0] beat_addr,
  output logic [IW-1:0] beat_id,
  output logic [7:0]    beat_idx,
  output logic          beat_last,
  output logic          err,
  output logic          dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    burst_e        burst;
  } aw_req_t;

  // Both channels transfer on a rising edge where valid && ready; valid never waits on ready.
  logic          aw_hs;
  logic [AW-1:0] size_mask, total_bytes, start_al, end_addr;
  logic          rsvd, wrap_bad, crosses;
  burst_e        eff_burst;

  assign aw_hs       = AWVALID && AWREADY;
  assign size_mask   = AW'((64'd1 << AWSIZE) - 64'd1);
  assign total_bytes = AW'((64'(AWLEN) + 64'd1) << AWSIZE);
  assign start_al    = AWADDR & ~size_mask;
  assign end_addr    = start_al + total_bytes - AW'(1);
  assign rsvd        = (AWBURST == BURST_RSVD);
  assign wrap_bad    = (AWBURST == BURST_WRAP) &&
                       (!(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((AWADDR & size_mask) != '0));
  assign eff_burst   = (rsvd || wrap_bad) ? BURST_INCR : burst_e'(AWBURST);
  assign crosses     = (eff_burst == BURST_INCR) &&
                       ((start_al >> BOUNDARY_SHIFT) != (end_addr >> BOUNDARY_SHIFT));

  // Requests land in a staging register first; illegal bursts are already rewritten to INCR there.
  logic    stg_valid;
  aw_req_t stg_req;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stg_valid <= 1'b0;
      stg_req   <= '0;
      err       <= 1'b0;
    end else begin
      stg_valid <= aw_hs;
      err       <= aw_hs && (rsvd || wrap_bad || crosses);
      if (aw_hs) stg_req <= '{id: AWID, addr: AWADDR, len: AWLEN, size: AWSIZE, burst: eff_burst};
    end
  end

  aw_req_t       head;
  logic          fifo_full, fifo_empty, pop;
  logic [CW-1:0] fifo_count, occupancy;

  rh_axi4_aw_fifo #(.DEPTH(DEPTH), .T(aw_req_t)) u_fifo (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (stg_valid),
    .wdata (stg_req),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The staged entry counts as occupied so the FIFO can always absorb it.
  assign occupancy = fifo_count + CW'(stg_valid);
  assign AWREADY   = !ARESET && !fifo_full && (occupancy != CW'(DEPTH));

  gen_state_e    state;
  logic [7:0]    cur_len;
  logic [2:0]    cur_size;
  burst_e        cur_burst;
  logic [AW-1:0] wrap_low, span, span_c, next_addr;

  assign pop       = !fifo_empty && ((state == GEN_IDLE) || (beat_valid && beat_ready && beat_last));
  assign span_c    = AW'((64'(head.len) + 64'd1) << head.size);
  assign next_addr = AW'(next_beat_addr(64'(beat_addr), cur_size, cur_burst, 64'(wrap_low), 64'(span)));
  assign dbg_state = state;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= GEN_IDLE;
      beat_valid <= 1'b0;
      beat_addr  <= '0;
      beat_id    <= '0;
      beat_idx   <= '0;
      beat_last  <= 1'b0;
      cur_len    <= '0;
      cur_size   <= '0;
      cur_burst  <= BURST_FIXED;
      wrap_low   <= '0;
      span       <= '0;
    end else if (pop) begin
      state      <= GEN_BURST;
      beat_valid <= 1'b1;
      beat_addr  <= head.addr;
      beat_id    <= head.id;
      beat_idx   <= '0;
      beat_last  <= (head.len == 8'd0);
      cur_len    <= head.len;
      cur_size   <= head.size;
      cur_burst  <= head.burst;
      span       <= span_c;
      wrap_low   <= head.addr & ~(span_c - AW'(1));
    end else if (state == GEN_BURST && beat_ready) begin
      if (beat_last) begin
        state      <= GEN_IDLE;
        beat_valid <= 1'b0;
        beat_last  <= 1'b0;
      end else begin
        beat_idx  <= beat_idx + 8'd1;
        beat_addr <= next_addr;
        beat_last <= (beat_idx + 8'd1 == cur_len);
      end
    end
  end

endmodule

// File: tb/tb_rh_axi4_aw_burst_gen.sv
// Directed bench for rh_axi4_aw_burst_gen with a queue-based beat/err scoreboard.
module tb_rh_axi4_aw_burst_gen;

  localparam int IW = 4;
  localparam int AW = 32;
  localparam int W  = IW + AW + 8 + 1;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          AWVALID, AWREADY;
  logic [IW-1:0] AWID;
  logic [AW-1:0] AWADDR;
  logic [7:0]    AWLEN;
  logic [2:0]    AWSIZE;
  logic [1:0]    AWBURST;
  logic          beat_valid, beat_ready, beat_last, err, dbg_state;
  logic [AW-1:0] beat_addr;
  logic [IW-1:0] beat_id;
  logic [7:0]    beat_idx;

  rh_axi4_aw_burst_gen #(.IW(IW), .AW(AW), .DEPTH(4)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .AWVALID    (AWVALID),
    .AWREADY    (AWREADY),
    .AWID       (AWID),
    .AWADDR     (AWADDR),
    .AWLEN      (AWLEN),
    .AWSIZE     (AWSIZE),
    .AWBURST    (AWBURST),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_id    (beat_id),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [W-1:0]  exp_q[$];
  logic          err_q[$];
  logic [AW-1:0] vec[$];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_burst(input logic [IW-1:0] id, input int total);
    for (int i = 0; i < vec.size(); i++)
      exp_q.push_back({id, vec[i], 8'(i), (i == total - 1)});
  endtask

  // Driver tasks: called #1 after a rising edge, return #1 after the handshake edge.
  task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic exp_err);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    err_q.push_back(exp_err);
    AWVALID = 1'b1;
    AWID    = id;
    AWADDR  = addr;
    AWLEN   = len;
    AWSIZE  = size;
    AWBURST = burst;
    while (!done && n < 50) begin
      @(negedge ACLK);
      if (AWREADY) done = 1'b1;
      n++;
    end
    if (!done) begin
      check("aw_handshake_timeout", 64'(done), 64'd1);
      void'(err_q.pop_back());
    end
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge ACLK);
    #1;
  endtask

  // Monitor: pops expectations on each beat handshake and each AW handshake's err slot.
  logic         aw_pend = 1'b0;
  logic         hold_valid = 1'b0;
  logic [W-1:0] hold_val;

  always @(negedge ACLK) begin
    logic [W-1:0] got;
    got = {beat_id, beat_addr, beat_idx, beat_last};
    if (aw_pend) begin
      if (err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL err_slot: got handshake with no expectation, err=%b", err);
      end else begin
        check("err_pulse", 64'(err), 64'(err_q.pop_front()));
      end
    end else if (err) begin
      check("err_spurious", 64'(err), 64'd0);
    end
    aw_pend = AWVALID && AWREADY;
    if (beat_valid && beat_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got %h expected none", got);
      end else begin
        check("beat", 64'(got), 64'(exp_q.pop_front()));
      end
    end
    if (beat_valid && !beat_ready) begin
      if (hold_valid) check("beat_hold", 64'(got), 64'(hold_val));
      hold_val   = got;
      hold_valid = 1'b1;
    end else begin
      hold_valid = 1'b0;
    end
  end

  // Directed stimulus
  initial begin
    int lat;
    int n;
    int stale;
    ARESET = 1'b1; AWVALID = 1'b0; AWID = '0; AWADDR = '0; AWLEN = '0;
    AWSIZE = '0; AWBURST = '0; beat_ready = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_beat_valid", 64'(beat_valid), 64'd0);
    check("rst_beat_addr", 64'(beat_addr), 64'd0);
    check("rst_beat_id", 64'(beat_id), 64'd0);
    check("rst_beat_idx", 64'(beat_idx), 64'd0);
    check("rst_beat_last", 64'(beat_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("awready_after_rst", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1;

    // INCR with unaligned-free start, plus first-beat latency
    beat_ready = 1'b1;
    vec = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
    exp_burst(4'h1, 4);
    aw_send(4'h1, 32'h1004, 8'd3, 3'd2, 2'b01, 1'b0);
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
    end while (!beat_valid && lat < 20);
    check("incr_first_beat_latency", 64'(lat), 64'd3);
    wait_drain("incr_drain");

    // WRAP
    vec = '{32'h38, 32'h20, 32'h28, 32'h30};
    exp_burst(4'h2, 4);
    aw_send(4'h2, 32'h38, 8'd3, 3'd3, 2'b10, 1'b0);
    wait_drain("wrap_drain");

    // FIXED followed by unaligned INCR
    vec = '{32'h200, 32'h200, 32'h200};
    exp_burst(4'h3, 3);
    vec = '{32'h103, 32'h104};
    exp_burst(4'h4, 2);
    aw_send(4'h3, 32'h200, 8'd2, 3'd2, 2'b00, 1'b0);
    aw_send(4'h4, 32'h103, 8'd1, 3'd2, 2'b01, 1'b0);
    wait_drain("fixed_incr_drain");

    // Backpressure until the request buffer is full, then drain without bubbles
    beat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vec = '{32'h2000 + 32'(i) * 32'h100, 32'h2004 + 32'(i) * 32'h100};
      exp_burst(IW'(5 + i), 2);
      aw_send(IW'(5 + i), 32'h2000 + 32'(i) * 32'h100, 8'd1, 3'd2, 2'b01, 1'b0);
    end
    repeat (3) @(negedge ACLK);
    check("awready_full", 64'(AWREADY), 64'd0);
    @(posedge ACLK); #1;
    beat_ready = 1'b1;
    repeat (10) @(negedge ACLK);
    #1;
    check("drain_no_bubble", 64'(exp_q.size()), 64'd0);
    @(posedge ACLK); #1;
    check("awready_after_drain", 64'(AWREADY), 64'd1);

    // Illegal requests: reserved burst, bad WRAP length, INCR across 4 KB
    vec = '{32'h300, 32'h304};
    exp_burst(4'hA, 2);
    vec = '{32'h400, 32'h404, 32'h408};
    exp_burst(4'hB, 3);
    vec = '{32'hFFC, 32'h1000};
    exp_burst(4'hC, 2);
    aw_send(4'hA, 32'h300, 8'd1, 3'd2, 2'b11, 1'b1);
    aw_send(4'hB, 32'h400, 8'd2, 3'd2, 2'b10, 1'b1);
    aw_send(4'hC, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b1);
    wait_drain("illegal_drain");
    repeat (2) @(negedge ACLK);
    #1;
    check("err_queue_empty", 64'(err_q.size()), 64'd0);
    @(posedge ACLK); #1;

    // Reset at beat 2 of an 8-beat burst with two requests queued behind it
    vec = '{32'h500, 32'h504};
    exp_burst(4'hD, 8);
    aw_send(4'hD, 32'h500, 8'd7, 3'd2, 2'b01, 1'b0);
    aw_send(4'hE, 32'h600, 8'd0, 3'd2, 2'b01, 1'b0);
    aw_send(4'hF, 32'h700, 8'd0, 3'd2, 2'b01, 1'b0);
    n = 0;
    while (!(beat_valid && beat_idx == 8'd2) && n < 30) begin
      @(posedge ACLK); #1;
      n++;
    end
    check("reach_beat2", 64'(beat_idx), 64'd2);
    ARESET = 1'b1;
    beat_ready = 1'b0;
    #1;
    check("midrst_beat_valid", 64'(beat_valid), 64'd0);
    check("midrst_beat_addr", 64'(beat_addr), 64'd0);
    check("midrst_beat_idx", 64'(beat_idx), 64'd0);
    check("midrst_beat_id", 64'(beat_id), 64'd0);
    check("midrst_awready", 64'(AWREADY), 64'd0);
    check("midrst_beats_seen", 64'(exp_q.size()), 64'd0);
    @(posedge ACLK);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    beat_ready = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge ACLK);
      if (beat_valid) stale++;
    end
    check("no_stale_beats", 64'(stale), 64'd0);
    check("awready_after_midrst", 64'(AWREADY), 64'd1);
    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    check("final_err_empty", 64'(err_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
